div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside the single-cycle ALU and multiplier. It accepts latched operands on a start pulse, computes one quotient bit per cycle, and presents a 32-bit result with a one-cycle done pulse for the EX/MEM register. While it is busy, the hazard logic stalls PC, IF/ID and ID/EX.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- start  in  1  request a division; accepted only in IDLE.
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1 value (ID/EX rd1), sampled when start is accepted.
- divisor  in  32  rs2 value, sampled when start is accepted.
- flush  in  1  abort the current operation (branch/exception squash).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  32  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch op and operands.
  - Compute |dividend| and |divisor| for signed ops.
  - Record quotient sign (signs differ) and remainder sign (dividend sign).
  - Special case detected: go to DONE with result preloaded.
  - Otherwise: clear the 33-bit partial remainder, load the count to 31, go to CALC.
- CALC, each cycle (restoring division):
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude from rem.
  - If nonnegative, keep the difference and set the quo LSB to 1.
  - Decrement the count; after the count-0 iteration go to DONE.
- DONE:
  - Assert done=1, busy=1.
  - result = quotient (op[1]=0) or remainder (op[1]=1), two's-complement negated per the recorded signs.
  - Next state IDLE.
- Special cases (RISC-V spec):
  - divisor=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - DIV with dividend=0x80000000, divisor=0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
- start while busy (including the DONE cycle) is ignored; no queueing.
- Operand/op changes after acceptance have no effect.
- flush in CALC or DONE: next state IDLE, no done pulse, result keeps its prior value. flush in IDLE blocks a same-cycle start.
- Priority: reset > flush > start.
- All arithmetic is unsigned on magnitudes. Negation is 32-bit modulo 2^32, so a magnitude of 0x80000000 is handled correctly.

## Timing
- Reset (reset=0 at a clk edge): state IDLE, busy=0, done=0, result=0, count=0. Reset mid-CALC aborts with no done pulse.
- Start accepted at edge E0 (cycle 0 = cycle in which start=1):
  - Normal op: busy=1 in cycles 1–33; CALC occupies cycles 1–32; done=1 and result valid in cycle 33; busy=0 from cycle 34.
  - Special case: done=1 and busy=1 in cycle 1; busy=0 from cycle 2.
- done is never high for more than one consecutive cycle.
- The earliest next accepted start is cycle 34 (normal) or cycle 2 (special).
- result changes only at the edge entering DONE, or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- DIVU 100/7 at cycle 0 → busy 1–33, done only in cycle 33, result 14. Repeat as REMU → 2.
- DIV 0xFFFFFFEC/3 (−20/3) → 0xFFFFFFFA (−6). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1. DIV 0x80000000/1 → 0x80000000.
- Divisor 0:
  - DIV 5/0 → 0xFFFFFFFF, done in cycle 1.
  - REMU 0x1234/0 → 0x1234, done in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 in cycle 1; REM with the same operands → 0.
- Start DIVU 1000/10, then:
  - Change the operands and pulse start in cycle 5 → ignored; result 100 in cycle 33.
  - Assert start in cycle 33 (DONE) → ignored; busy=0 in cycle 34.
- Start DIVU 50/5, assert flush in cycle 10:
  - busy=0 from cycle 11, no done pulse, result still the previous value.
  - New start DIVU 9/3 in cycle 11 → result 3 with done in cycle 44.
- reset=0 in cycle 12 of an operation → next cycle busy=0, done=0, result=0. No done pulse appears through cycle 40.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle. Divide-by-zero and signed overflow finish in a single cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs_mag;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            rem_sel;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic            accept;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN:0]   rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_val;
    logic [XLEN-1:0] r_val;
    logic [XLEN-1:0] fin_result;

    // Operand decode at acceptance time; overflow result equals the dividend (0x80000000).
    always_comb begin
        is_signed      = ~op[0];
        a_neg          = is_signed & dividend[XLEN-1];
        b_neg          = is_signed & divisor[XLEN-1];
        a_mag          = a_neg ? -dividend : dividend;
        b_mag          = b_neg ? -divisor : divisor;
        div_zero       = (divisor == '0);
        ovf            = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
        special        = div_zero | ovf;
        special_result = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
        accept         = (state == IDLE) && start && !flush;
    end

    // One restoring step, plus the sign-corrected result for the final iteration.
    always_comb begin
        rem_sh     = {rem[XLEN-1:0], quo[XLEN-1]};
        diff       = rem_sh - {1'b0, dvs_mag};
        rem_nx     = diff[XLEN] ? rem_sh : diff;
        quo_nx     = {quo[XLEN-2:0], ~diff[XLEN]};
        q_val      = q_neg ? -quo_nx : quo_nx;
        r_val      = r_neg ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        fin_result = rem_sel ? r_val : q_val;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = special ? DONE : CALC;
            CALC: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // result is written only on the edge that enters DONE, so a flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem     <= '0;
            quo     <= '0;
            dvs_mag <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            rem_sel <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            rem     <= '0;
            quo     <= a_mag;
            dvs_mag <= b_mag;
            cnt     <= CW'(XLEN-1);
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            rem_sel <= op[1];
            if (special) begin
                result <= special_result;
            end
        end else if (state == CALC && !flush) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                result <= fin_result;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: cycle-exact busy/done timing,
// signed/unsigned results, special cases, ignored starts, flush and reset.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int fails  = 0;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Launch an op in the current cycle (cycle 0) and check every cycle up to lat+1.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected, input int lat, input string name);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            checkOutput($sformatf("%s busy_done c%0d", name, c), {30'd0, busy, done},
                        (c == lat) ? 32'd3 : 32'd2);
            if (c == lat) checkOutput({name, " result"}, result, expected);
            tick();
        end
        checkOutput({name, " idle after"}, {30'd0, busy, done}, 32'd0);
        checkOutput({name, " result held"}, result, expected);
    endtask

    initial begin
        int done_seen;
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        reset = 1'b1;
        checkOutput("reset busy_done", {30'd0, busy, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu100_7");
        applyStimulus(OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu100_7");
        applyStimulus(OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, "div-20_3");
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem-7_2");
        applyStimulus(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem7_-2");
        applyStimulus(OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 33, "divmin_1");

        applyStimulus(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div5_0");
        applyStimulus(OP_REMU, 32'h1234, 32'd0, 32'h1234, 1, "remu1234_0");
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

        // Starts while busy (mid-CALC with new operands, and in DONE) are ignored.
        op = OP_DIVU;
        dividend = 32'd1000;
        divisor = 32'd10;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 33; c++) begin
            start = (c == 5) || (c == 33);
            if (c == 5) begin
                dividend = 32'd77;
                divisor = 32'd7;
                op = OP_REMU;
            end
            checkOutput($sformatf("ignore busy_done c%0d", c), {30'd0, busy, done},
                        (c == 33) ? 32'd3 : 32'd2);
            tick();
        end
        start = 1'b0;
        checkOutput("ignore result", result, 32'd100);
        checkOutput("ignore idle c34", {30'd0, busy, done}, 32'd0);
        tick();
        checkOutput("ignore idle c35", {30'd0, busy, done}, 32'd0);

        // Flush mid-CALC: no done pulse, result keeps 100.
        op = OP_DIVU;
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            flush = (c == 10);
            checkOutput($sformatf("flush busy_done c%0d", c), {30'd0, busy, done}, 32'd2);
            tick();
        end
        flush = 1'b0;
        checkOutput("flush idle c11", {30'd0, busy, done}, 32'd0);
        checkOutput("flush result kept", result, 32'd100);
        applyStimulus(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu9_3");

        // Reset in cycle 12 aborts the op and clears result.
        op = OP_DIVU;
        dividend = 32'd1000;
        divisor = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            reset = (c == 12) ? 1'b0 : 1'b1;
            checkOutput($sformatf("rst busy_done c%0d", c), {30'd0, busy, done}, 32'd2);
            tick();
        end
        reset = 1'b1;
        checkOutput("rst busy_done c13", {30'd0, busy, done}, 32'd0);
        checkOutput("rst result c13", result, 32'd0);
        done_seen = 0;
        for (int c = 13; c <= 40; c++) begin
            if (done) done_seen++;
            tick();
        end
        checkOutput("rst no done pulse", done_seen, 32'd0);
        checkOutput("rst still idle", {30'd0, busy, done}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
